// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and write-request bundle for the register-file write-port arbiter.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN_DEF   = 32;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] wa;
        logic [XLEN_DEF-1:0]   wd;
    } wr_req_t;

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Pipeline-side bundle of the write-port arbiter: writeback, long-latency unit, decode and regfile port.
interface regfile_wb_arbiter_if
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREG = 32
);

    logic                  wb_we;
    logic [REG_ADDR_W-1:0] wb_wa;
    logic [XLEN-1:0]       wb_wd;

    logic                  lu_issue;
    logic [REG_ADDR_W-1:0] lu_issue_rd;
    logic                  lu_valid;
    logic [REG_ADDR_W-1:0] lu_wa;
    logic [XLEN-1:0]       lu_wd;
    logic                  lu_ready;

    logic                  dec_valid;
    logic [REG_ADDR_W-1:0] dec_ra1;
    logic [REG_ADDR_W-1:0] dec_ra2;
    logic [REG_ADDR_W-1:0] dec_rd;
    logic                  hazard_stall;
    logic                  stall_req;

    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_wa;
    logic [XLEN-1:0]       rf_wd;
    logic [NREG-1:0]       pending;

    modport master (
        output wb_we, wb_wa, wb_wd,
        output lu_issue, lu_issue_rd, lu_valid, lu_wa, lu_wd,
        output dec_valid, dec_ra1, dec_ra2, dec_rd,
        input  lu_ready, hazard_stall, stall_req,
        input  rf_we, rf_wa, rf_wd, pending
    );

    modport slave (
        input  wb_we, wb_wa, wb_wd,
        input  lu_issue, lu_issue_rd, lu_valid, lu_wa, lu_wd,
        input  dec_valid, dec_ra1, dec_ra2, dec_rd,
        output lu_ready, hazard_stall, stall_req,
        output rf_we, rf_wa, rf_wd, pending
    );

endinterface

// File: rtl/regfile_wb_arbiter_wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the regfile write port is free.
module wb_fifo #(
    parameter int W     = 38,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (do_pop && !do_push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Owns the regfile write port: arbitrates pipeline writeback against buffered long-latency
// results, tracks outstanding long-latency destinations and requests a bubble on starvation.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int NREG       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    regfile_wb_arbiter_if.slave bus
);

    localparam int SW = $clog2(STARVE_MAX + 1);

    wr_req_t         wb_req;
    wr_req_t         lu_req;
    wr_req_t         head;
    wr_req_t         rf_d;
    wr_req_t         rf_q;
    logic            wb_win;
    logic            lu_live;
    logic            pop;
    logic            push;
    logic            bypass;
    logic            lu_ready;
    logic            fifo_full;
    logic            fifo_empty;
    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] pend_set;
    logic [NREG-1:0] pend_clr;
    logic [SW-1:0]   starve_left;
    logic            stall_q;

    assign wb_req = '{we: bus.wb_we,    wa: bus.wb_wa, wd: bus.wb_wd};
    assign lu_req = '{we: bus.lu_valid, wa: bus.lu_wa, wd: bus.lu_wd};

    wb_fifo #(
        .W     ($bits(wr_req_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (lu_req),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        wb_win   = wb_req.we && (wb_req.wa != '0);
        lu_live  = lu_req.we && (lu_req.wa != '0);
        pop      = !wb_win && !fifo_empty;
        bypass   = !wb_win && fifo_empty && lu_live;
        lu_ready = !fifo_full || pop;
        // Results addressed to x0 are accepted on the handshake but never stored.
        push     = lu_live && lu_ready && !bypass;

        rf_d = '0;
        if (wb_win)      rf_d = wb_req;
        else if (pop)    rf_d = head;
        else if (bypass) rf_d = lu_req;

        pend_clr = '0;
        pend_set = '0;
        if (pop)         pend_clr[head.wa]   = 1'b1;
        else if (bypass) pend_clr[lu_req.wa] = 1'b1;
        if (bus.lu_issue && (bus.lu_issue_rd != '0)) pend_set[bus.lu_issue_rd] = 1'b1;

        pending_d = ((pending_q & ~pend_clr) | pend_set) & ~{{(NREG-1){1'b0}}, 1'b1};
    end

    // Starvation timer counts down denied cycles; reaching one on a denial fires the bubble request.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_q        <= '0;
            pending_q   <= '0;
            starve_left <= SW'(STARVE_MAX);
            stall_q     <= 1'b0;
        end else begin
            rf_q      <= rf_d;
            pending_q <= pending_d;
            stall_q   <= 1'b0;
            if (fifo_empty || pop) begin
                starve_left <= SW'(STARVE_MAX);
            end else if (starve_left == SW'(1)) begin
                stall_q     <= 1'b1;
                starve_left <= SW'(STARVE_MAX);
            end else begin
                starve_left <= starve_left - SW'(1);
            end
        end
    end

    assign bus.lu_ready     = lu_ready;
    assign bus.hazard_stall = bus.dec_valid &&
                              (pending_q[bus.dec_ra1] || pending_q[bus.dec_ra2] || pending_q[bus.dec_rd]);
    assign bus.stall_req    = stall_q;
    assign bus.rf_we        = rf_q.we;
    assign bus.rf_wa        = rf_q.wa;
    assign bus.rf_wd        = rf_q.wd[XLEN-1:0];
    assign bus.pending      = pending_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, reset-in-flight sequence, randomized run vs queue model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int SMAX  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if bus ();

    regfile_wb_arbiter #(
        .XLEN       (32),
        .NREG       (32),
        .FIFO_DEPTH (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic        wb_we;
        logic [4:0]  wb_wa;
        logic [31:0] wb_wd;
        logic        lu_issue;
        logic [4:0]  lu_rd;
        logic        lu_valid;
        logic [4:0]  lu_wa;
        logic [31:0] lu_wd;
        logic        dec_valid;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [4:0]  rd;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        ready;
        logic        haz;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        stall;
        logic [31:0] pend;
    } vec_t;

    typedef struct {
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    int          total = 0;
    int          bad   = 0;
    ent_t        mq[$];
    logic [31:0] mpend;
    int          mstarve;
    vec_t        tbl[21];

    function automatic stim_t mk(input logic wbwe, input logic [4:0] wbwa, input logic [31:0] wbwd,
                                 input logic iss, input logic [4:0] ird,
                                 input logic luv, input logic [4:0] luwa, input logic [31:0] luwd,
                                 input logic dv, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd);
        stim_t s;
        s.wb_we = wbwe; s.wb_wa = wbwa; s.wb_wd = wbwd;
        s.lu_issue = iss; s.lu_rd = ird;
        s.lu_valid = luv; s.lu_wa = luwa; s.lu_wd = luwd;
        s.dec_valid = dv; s.ra1 = r1; s.ra2 = r2; s.rd = rd;
        return s;
    endfunction

    function automatic vec_t row(input stim_t s, input logic ready, input logic haz, input logic we,
                                 input logic [4:0] wa, input logic [31:0] wd, input logic stall,
                                 input logic [31:0] pend);
        vec_t v;
        v.s = s; v.ready = ready; v.haz = haz; v.we = we; v.wa = wa; v.wd = wd;
        v.stall = stall; v.pend = pend;
        return v;
    endfunction

    function automatic stim_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input stim_t s);
        bus.wb_we       = s.wb_we;
        bus.wb_wa       = s.wb_wa;
        bus.wb_wd       = s.wb_wd;
        bus.lu_issue    = s.lu_issue;
        bus.lu_issue_rd = s.lu_rd;
        bus.lu_valid    = s.lu_valid;
        bus.lu_wa       = s.lu_wa;
        bus.lu_wd       = s.lu_wd;
        bus.dec_valid   = s.dec_valid;
        bus.dec_ra1     = s.ra1;
        bus.dec_ra2     = s.ra2;
        bus.dec_rd      = s.rd;
    endtask

    // Called at posedge+1: drive, check combinational outputs mid-cycle, then registered ones after the edge.
    task automatic run_vec(input string tag, input vec_t v);
        drive(v.s);
        #3;
        chk({tag, " lu_ready"}, 32'(bus.lu_ready), 32'(v.ready));
        chk({tag, " hazard_stall"}, 32'(bus.hazard_stall), 32'(v.haz));
        @(posedge clk);
        #1;
        chk({tag, " rf_we"}, 32'(bus.rf_we), 32'(v.we));
        if (v.we) begin
            chk({tag, " rf_wa"}, 32'(bus.rf_wa), 32'(v.wa));
            chk({tag, " rf_wd"}, bus.rf_wd, v.wd);
        end
        chk({tag, " stall_req"}, 32'(bus.stall_req), 32'(v.stall));
        chk({tag, " pending"}, bus.pending, v.pend);
    endtask

    task automatic reset_cycle(input string tag);
        reset = 1'b1;
        drive(idle());
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk({tag, " rf_we"}, 32'(bus.rf_we), 32'd0);
        chk({tag, " stall_req"}, 32'(bus.stall_req), 32'd0);
        chk({tag, " pending"}, bus.pending, 32'd0);
        mq.delete();
        mpend   = '0;
        mstarve = 0;
    endtask

    // Reference: completion queue, pending bit array and an up-counting count of denied cycles.
    task automatic model_step(input stim_t s, output vec_t e);
        logic wbw;
        logic popped;
        logic byp;
        int   sz;
        ent_t h;
        e.s    = s;
        sz     = mq.size();
        wbw    = s.wb_we && (s.wb_wa != 0);
        e.haz  = s.dec_valid && (mpend[s.ra1] || mpend[s.ra2] || mpend[s.rd]);
        popped = !wbw && (sz > 0);
        e.ready = (sz < DEPTH) || popped;
        byp    = !wbw && (sz == 0) && s.lu_valid && (s.lu_wa != 0);
        e.we = 1'b0; e.wa = '0; e.wd = '0;
        if (wbw) begin
            e.we = 1'b1; e.wa = s.wb_wa; e.wd = s.wb_wd;
        end else if (popped) begin
            h = mq.pop_front();
            e.we = 1'b1; e.wa = h.wa; e.wd = h.wd;
            mpend[h.wa] = 1'b0;
        end else if (byp) begin
            e.we = 1'b1; e.wa = s.lu_wa; e.wd = s.lu_wd;
            mpend[s.lu_wa] = 1'b0;
        end
        if (s.lu_valid && e.ready && (s.lu_wa != 0) && !byp) mq.push_back('{s.lu_wa, s.lu_wd});
        e.stall = 1'b0;
        if ((sz == 0) || popped) begin
            mstarve = 0;
        end else begin
            mstarve++;
            if (mstarve == SMAX) begin
                e.stall = 1'b1;
                mstarve = 0;
            end
        end
        if (s.lu_issue && (s.lu_rd != 0)) mpend[s.lu_rd] = 1'b1;
        mpend[0] = 1'b0;
        e.pend   = mpend;
    endtask

    initial begin
        localparam logic [31:0] P7  = 32'h0000_0080;
        localparam logic [31:0] P9  = 32'h0000_0200;
        localparam logic [31:0] P12 = 32'h0000_1000;

        tbl[0]  = row(mk(1, 5, 32'hA5, 0, 0, 0, 0, 0, 0, 0, 0, 0),            1, 0, 1, 5, 32'hA5, 0, 0);
        tbl[1]  = row(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0),                 1, 0, 0, 0, 0, 0, P7);
        tbl[2]  = row(idle(),                                                  1, 0, 0, 0, 0, 0, P7);
        tbl[3]  = row(idle(),                                                  1, 0, 0, 0, 0, 0, P7);
        tbl[4]  = row(mk(0, 0, 0, 0, 0, 1, 7, 32'h1234, 0, 0, 0, 0),          1, 0, 1, 7, 32'h1234, 0, 0);
        tbl[5]  = row(mk(1, 3, 32'h33, 1, 9, 1, 8, 32'h88, 0, 0, 0, 0),       1, 0, 1, 3, 32'h33, 0, P9);
        tbl[6]  = row(idle(),                                                  1, 0, 1, 8, 32'h88, 0, P9);
        tbl[7]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 2),                 1, 1, 0, 0, 0, 0, P9);
        tbl[8]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 9),                 1, 1, 0, 0, 0, 0, P9);
        tbl[9]  = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 4),                 1, 0, 0, 0, 0, 0, P9);
        tbl[10] = row(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 9, 9, 9),                 1, 0, 0, 0, 0, 0, P9);
        tbl[11] = row(mk(1, 1, 32'h1, 0, 0, 1, 10, 32'hA0, 0, 0, 0, 0),       1, 0, 1, 1, 32'h1, 0, P9);
        tbl[12] = row(mk(1, 2, 32'h2, 0, 0, 1, 11, 32'hB0, 0, 0, 0, 0),       1, 0, 1, 2, 32'h2, 0, P9);
        tbl[13] = row(mk(1, 3, 32'h3, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0),       0, 0, 1, 3, 32'h3, 0, P9);
        tbl[14] = row(mk(1, 4, 32'h4, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0),       0, 0, 1, 4, 32'h4, 0, P9);
        tbl[15] = row(mk(1, 5, 32'h5, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0),       0, 0, 1, 5, 32'h5, 1, P9);
        tbl[16] = row(mk(0, 0, 0, 0, 0, 1, 12, 32'hC0, 0, 0, 0, 0),           1, 0, 1, 10, 32'hA0, 0, P9);
        tbl[17] = row(idle(),                                                  1, 0, 1, 11, 32'hB0, 0, P9);
        tbl[18] = row(mk(0, 0, 0, 1, 12, 0, 0, 0, 0, 0, 0, 0),                1, 0, 1, 12, 32'hC0, 0, P9 | P12);
        tbl[19] = row(mk(1, 0, 32'hFF, 1, 0, 1, 0, 32'hEE, 0, 0, 0, 0),       1, 0, 0, 0, 0, 0, P9 | P12);
        tbl[20] = row(idle(),                                                  1, 0, 0, 0, 0, 0, P9 | P12);

        reset = 1'b1;
        drive(idle());
        repeat (2) @(posedge clk);
        #1;
        chk("reset rf_we", 32'(bus.rf_we), 32'd0);
        chk("reset rf_wa", 32'(bus.rf_wa), 32'd0);
        chk("reset rf_wd", bus.rf_wd, 32'd0);
        chk("reset stall_req", 32'(bus.stall_req), 32'd0);
        chk("reset pending", bus.pending, 32'd0);
        chk("reset lu_ready", 32'(bus.lu_ready), 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 21; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Fill the FIFO behind a busy writeback, then reset with results still buffered.
        run_vec("mid_a", row(mk(1, 1, 32'h1, 0, 0, 1, 13, 32'hD0, 0, 0, 0, 0), 1, 0, 1, 1, 32'h1, 0, P9 | P12));
        run_vec("mid_b", row(mk(1, 2, 32'h2, 0, 0, 1, 14, 32'hE0, 0, 0, 0, 0), 1, 0, 1, 2, 32'h2, 0, P9 | P12));
        run_vec("mid_c", row(mk(1, 3, 32'h3, 0, 0, 1, 15, 32'hF0, 0, 0, 0, 0), 0, 0, 1, 3, 32'h3, 0, P9 | P12));
        reset_cycle("mid_rst");
        for (int i = 0; i < 6; i++)
            run_vec($sformatf("post_rst%0d", i), row(idle(), 1, 0, 0, 0, 0, 0, 0));

        reset_cycle("rand_rst");
        for (int n = 0; n < 600; n++) begin
            stim_t s;
            vec_t  e;
            int    dens;
            dens = ((n / 60) % 2 == 0) ? 3 : 1;
            s.wb_we     = ($urandom_range(0, 3) < dens);
            s.wb_wa     = 5'($urandom_range(0, 7));
            s.wb_wd     = $urandom;
            s.lu_issue  = ($urandom_range(0, 3) == 0);
            s.lu_rd     = 5'($urandom_range(0, 15));
            s.lu_valid  = ($urandom_range(0, 1) == 1);
            s.lu_wa     = 5'($urandom_range(0, 15));
            s.lu_wd     = $urandom;
            s.dec_valid = ($urandom_range(0, 1) == 1);
            s.ra1       = 5'($urandom_range(0, 15));
            s.ra2       = 5'($urandom_range(0, 15));
            s.rd        = 5'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) begin
                reset_cycle($sformatf("rand%0d reset", n));
            end else begin
                model_step(s, e);
                run_vec($sformatf("rand%0d", n), e);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Owns the single write port (we3/wa3/wd3) of the register file.
- Shares that port between the in-order pipeline writeback and a multi-cycle long-latency unit (mul/div), buffering long-latency results in a small FIFO.
- Keeps a per-register pending scoreboard and raises a decode hazard stall for any source or destination register with an outstanding long-latency write.
- Requests a one-cycle pipeline bubble when a buffered result has been starved too long.

Parameters:
- XLEN, 32, data width.
- NREG, 32, architectural register count; address width is 5.
- FIFO_DEPTH, 2, long-latency completion buffer entries (power of 2, ≥1).
- STARVE_MAX, 4, consecutive cycles a non-empty FIFO may be denied the port before stall_req fires.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- wb_we  in  1  pipeline writeback valid.
- wb_wa  in  5  pipeline writeback address.
- wb_wd  in  XLEN  pipeline writeback data.
- lu_issue  in  1  long-latency op dispatched this cycle.
- lu_issue_rd  in  5  destination of the dispatched op.
- lu_valid  in  1  long-latency result valid.
- lu_wa  in  5  result address.
- lu_wd  in  XLEN  result data.
- lu_ready  out  1  FIFO can accept; lu_valid&&lu_ready is a transfer.
- dec_valid  in  1  decode-stage instruction valid.
- dec_ra1, dec_ra2, dec_rd  in  5 each  decode source/destination addresses.
- hazard_stall  out  1  combinational decode stall.
- stall_req  out  1  registered starvation bubble request.
- rf_we  out  1  to regfile we3; registered.
- rf_wa  out  5  to regfile wa3; registered.
- rf_wd  out  XLEN  to regfile wd3; registered.
- pending  out  NREG  scoreboard vector (debug).

Behaviour:
- Reset: clk/reset as above; reset synchronous, active-high. rf_we=0, rf_wa=0, rf_wd=0, stall_req=0, pending=0, FIFO emptied, starve counter=0. A mid-operation reset drops buffered results and all pending bits.
- Arbitration each cycle, highest priority first:
  - (a) wb_we && wb_wa≠0 → write WB.
  - (b) FIFO non-empty → pop head, write it.
  - (c) FIFO empty && lu_valid && lu_wa≠0 → bypass, write LU directly; the transfer does not enter the FIFO.
  - (d) otherwise rf_we=0.
- Latency: the winner appears on rf_* exactly 1 cycle after arbitration. The regfile commits it on the following negedge.
- FIFO and lu_ready:
  - LU transfers not bypassed are pushed.
  - lu_ready = !full || pop this cycle; push and pop in the same cycle is allowed when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - lu_valid with lu_wa=0 is accepted and discarded.
- Scoreboard:
  - lu_issue && lu_issue_rd≠0 sets pending[rd] at the next edge.
  - Writing an LU result (paths b/c) clears pending[wa] at the same edge rf_we rises.
  - Set and clear of the same bit in one cycle: set wins.
  - x0 is never pending.
- hazard_stall = dec_valid && (pending[dec_ra1] || pending[dec_ra2] || pending[dec_rd]), using the pre-update vector. Including dec_rd (WAW) guarantees WB and a buffered LU result never target the same register.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and WB wins; it clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_MAX, stall_req=1 for exactly one cycle and the counter clears.
  - Pipeline contract: wb_we=0 in the cycle after stall_req, so (b) wins. If wb_we is violated, WB still wins and the counter restarts.
- WB writes to x0 are ignored (treated as wb_we=0).

Decomposition:
- Shared package holds:
  - REG_ADDR_W=5.
  - The XLEN default.
  - Typedef wr_req_t {we, wa, wd}, used for wb, lu and rf bundles.
- One natural sub-module, wb_fifo: parameterised sync FIFO with push/pop/full/empty/head.
- Scoreboard, arbiter and starve counter stay in the top.

Test Plan:
- Reset, then WB only: wb_we=1, wa=5, wd=0xA5 → next cycle rf_we=1, rf_wa=5, rf_wd=0xA5; pending=0.
- Bypass: lu_issue rd=7; 3 cycles later lu_valid wa=7 wd=0x1234 with wb_we=0 → pending[7]=1 until rf_we=1/wa=7/wd=0x1234, same edge pending[7]=0.
- Conflict: lu_valid wa=8 and wb_we wa=3 same cycle → WB written first; LU buffered and written next cycle (wb_we=0); lu_ready stays 1.
- Full/backpressure (FIFO_DEPTH=2): wb_we held high and 3 LU results offered → 2 accepted, lu_ready=0 on the 3rd; after 4 denied cycles stall_req pulses 1 cycle; with wb_we=0 the head pops and lu_ready rises.
- Hazard: pending[9]=1, dec_valid with ra2=9 → hazard_stall=1. dec_rd=9 → hazard_stall=1. ra1=0, ra2=0, rd=4 → hazard_stall=0.
- Reset mid-op: FIFO holding 2 entries, pending[12]=1, assert reset 1 cycle → rf_we=0, pending=0, lu_ready=1, no buffered write ever appears.
